// File: rtl/decoder_3to8_reg.sv
// Registered binary-to-one-hot decoder with enable and a valid flag that
// travels alongside the decoded lanes; one clock of latency from i/en to q.
module decoder_3to8_reg #(
    parameter int IN_W           = 3,
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [IN_W-1:0]      i,
    output logic [2**IN_W-1:0]   q,
    output logic                 q_valid
);

    localparam int OUT_W = 2**IN_W;
    localparam logic [OUT_W-1:0] IDLE = OUT_ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    // An unknown code matches no lane, so the result falls back to idle.
    function automatic logic [OUT_W-1:0] one_hot(input logic [IN_W-1:0] code);
        logic [OUT_W-1:0] r;
        r = '0;
        for (int k = 0; k < OUT_W; k++) begin
            if (code == IN_W'(k)) begin
                r[k] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [OUT_W-1:0] apply_polarity(input logic [OUT_W-1:0] v);
        return OUT_ACTIVE_LOW ? ~v : v;
    endfunction

    logic [OUT_W-1:0] dec_p0;
    logic [OUT_W-1:0] q_p1;
    logic             vld_p1;

    // Stage p0: combinational decode of the sampled inputs
    always_comb begin
        dec_p0 = IDLE;
        if (en) begin
            dec_p0 = apply_polarity(one_hot(i));
        end
    end

    // Stage p1: output register; reset forces idle lanes immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_p1   <= IDLE;
            vld_p1 <= 1'b0;
        end else begin
            q_p1   <= dec_p0;
            vld_p1 <= en;
        end
    end

    assign q       = q_p1;
    assign q_valid = vld_p1;

endmodule

// File: tb/tb_decoder_3to8_reg.sv
// Scoreboard bench for decoder_3to8_reg: active-high and active-low instances
// share stimulus; a monitor compares both against a reference model queue.
module tb_decoder_3to8_reg;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] i;
    logic [7:0] q_hi, q_lo;
    logic       v_hi, v_lo;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] q_hi;
        logic [7:0] q_lo;
        logic       vld;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   step_id = 0;

    decoder_3to8_reg #(.IN_W(3), .OUT_ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk(clk), .rst(rst), .en(en), .i(i), .q(q_hi), .q_valid(v_hi)
    );

    decoder_3to8_reg #(.IN_W(3), .OUT_ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk(clk), .rst(rst), .en(en), .i(i), .q(q_lo), .q_valid(v_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int id, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, id, act, req);
        end
    endtask

    // Reference: selected lane is the power of two of the code; active-low is its complement.
    function automatic exp_t model(input logic e, input logic [2:0] code, input int id);
        exp_t x;
        int   lanes;
        lanes  = e ? (2 ** int'(code)) : 0;
        x.q_hi = 8'(lanes);
        x.q_lo = 8'(255 - lanes);
        x.vld  = e;
        x.id   = id;
        return x;
    endfunction

    task automatic issue(input logic e, input logic [2:0] code);
        en = e;
        i  = code;
        step_id++;
        sb.push_back(model(e, code, step_id));
    endtask

    task automatic step(input logic e, input logic [2:0] code);
        @(posedge clk);
        #3;
        issue(e, code);
    endtask

    // Monitor: outputs are meaningful every cycle, pop whenever an expectation is pending.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                check("q_hi", x.id, q_hi, x.q_hi);
                check("q_lo", x.id, q_lo, x.q_lo);
                check("valid_hi", x.id, {7'b0, v_hi}, {7'b0, x.vld});
                check("valid_lo", x.id, {7'b0, v_lo}, {7'b0, x.vld});
            end
        end
    end

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        i   = 3'b101;
        #2 rst = 1'b0;
        #1;
        check("reset_q_hi_pre_edge", 0, q_hi, 8'h00);
        check("reset_q_lo_pre_edge", 0, q_lo, 8'hFF);
        check("reset_valid_pre_edge", 0, {7'b0, v_hi}, 8'h00);
        repeat (2) begin
            @(negedge clk);
            check("reset_hold_q_hi", 0, q_hi, 8'h00);
            check("reset_hold_q_lo", 0, q_lo, 8'hFF);
            check("reset_hold_valid", 0, {7'b0, v_lo}, 8'h00);
        end
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 8; k++) step(1'b1, 3'(k));

        step(1'b1, 3'b010);
        step(1'b0, 3'b010);
        step(1'b1, 3'b010);

        // Mid-cycle change of i must not reach q before the next edge.
        step(1'b1, 3'b001);
        @(posedge clk);
        #5;
        issue(1'b1, 3'b110);
        #1;
        check("hold_q_hi", step_id, q_hi, 8'h02);
        check("hold_q_lo", step_id, q_lo, 8'hFD);

        // Async reset between edges while q shows lane 4.
        step(1'b1, 3'b100);
        @(posedge clk);
        #2;
        check("pre_async_q_hi", step_id, q_hi, 8'h10);
        rst = 1'b0;
        #1;
        check("async_q_hi", step_id, q_hi, 8'h00);
        check("async_q_lo", step_id, q_lo, 8'hFF);
        check("async_valid", step_id, {7'b0, v_hi}, 8'h00);
        #1 rst = 1'b1;
        step(1'b1, 3'b111);

        for (int n = 0; n < 300; n++) begin
            step(($urandom % 4) != 0, 3'($urandom_range(0, 7)));
        end
        step(1'b0, 3'b000);

        for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations pending, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
